// File: rtl/operand_feeder.sv
// Operand-pair FIFO feeding a combinational logic unit; the pair is visible the cycle after push, the result is captured on pop and shown one cycle later.
// in_ready depends only on registered occupancy, so a full buffer refuses a push even during a pop. FEEDER_PARITY_EN adds res_parity.
module operand_feeder #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_a,
  input  logic [WIDTH-1:0]           in_b,
  output logic [WIDTH-1:0]           a,
  output logic [WIDTH-1:0]           b,
  output logic                       out_valid,
  input  logic                       out_ready,
  input  logic [WIDTH-1:0]           result,
  output logic                       res_valid,
  output logic [WIDTH-1:0]           res_data,
`ifdef FEEDER_PARITY_EN
  output logic                       res_parity,
`endif
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_a [DEPTH];
  logic [WIDTH-1:0] mem_b [DEPTH];
  logic [PW-1:0]    wp;
  logic [PW-1:0]    rp;
  logic             push;
  logic             pop;

  // DEPTH is a power of two and count never exceeds it, so the MSB alone flags full.
  assign in_ready  = ~count[PW];
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  assign a = out_valid ? mem_a[rp] : '0;
  assign b = out_valid ? mem_b[rp] : '0;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[wp] <= in_a;
      mem_b[wp] <= in_b;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp        <= '0;
      rp        <= '0;
      count     <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      res_valid <= pop;
      if (pop) res_data <= result;
    end
  end

`ifdef FEEDER_PARITY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      res_parity <= 1'b0;
    else if (pop) res_parity <= ^result;
  end
`endif

endmodule

// File: tb/tb_operand_feeder.sv
// Directed bench for operand_feeder with a 4-bit XOR as the downstream logic unit.
module tb_operand_feeder;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_a;
  logic [3:0] in_b;
  logic [3:0] a;
  logic [3:0] b;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] result;
  logic       res_valid;
  logic [3:0] res_data;
  logic [2:0] count;
`ifdef FEEDER_PARITY_EN
  logic       res_parity;
`endif

  int total = 0;
  int bad   = 0;

  assign result = a ^ b;

  operand_feeder #(.WIDTH(4), .DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .res_valid (res_valid),
    .res_data  (res_data),
`ifdef FEEDER_PARITY_EN
    .res_parity(res_parity),
`endif
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_a = '0; in_b = '0;
    tick(); tick();
    total++; if (count !== 3'd0)   begin bad++; $display("FAIL rst_count: got %0d want 0", count); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL rst_res_valid: got %b want 0", res_valid); end
    total++; if (res_data !== 4'h0) begin bad++; $display("FAIL rst_res_data: got %h want 0", res_data); end
    total++; if (a !== 4'h0 || b !== 4'h0) begin bad++; $display("FAIL rst_ab: got %h/%h want 0/0", a, b); end
`ifdef FEEDER_PARITY_EN
    total++; if (res_parity !== 1'b0) begin bad++; $display("FAIL rst_parity: got %b want 0", res_parity); end
`endif
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    // out_ready high during the push into an empty buffer must not pop
    in_a = 4'b1101; in_b = 4'b0111; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL single_out_valid: got %b want 1", out_valid); end
    total++; if (a !== 4'b1101) begin bad++; $display("FAIL single_a: got %b want 1101", a); end
    total++; if (b !== 4'b0111) begin bad++; $display("FAIL single_b: got %b want 0111", b); end
    total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL single_no_early_pop: got %b want 0", res_valid); end
    total++; if (count !== 3'd1) begin bad++; $display("FAIL single_count: got %0d want 1", count); end
    tick();
    total++; if (res_valid !== 1'b1) begin bad++; $display("FAIL single_res_valid: got %b want 1", res_valid); end
    total++; if (res_data !== 4'b1010) begin bad++; $display("FAIL single_res_data: got %b want 1010", res_data); end
    total++; if (count !== 3'd0 || out_valid !== 1'b0 || a !== 4'h0) begin bad++; $display("FAIL single_drained: got count=%0d out_valid=%b a=%h want 0/0/0", count, out_valid, a); end
`ifdef FEEDER_PARITY_EN
    total++; if (res_parity !== 1'b0) begin bad++; $display("FAIL single_parity: got %b want 0", res_parity); end
`endif
    // out_ready with nothing buffered: no pulse, data held
    tick();
    total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL idle_res_valid: got %b want 0", res_valid); end
    total++; if (res_data !== 4'b1010) begin bad++; $display("FAIL idle_res_hold: got %b want 1010", res_data); end
    out_ready = 1'b0;
  endtask

  task automatic test_equal();
    in_a = 4'b1010; in_b = 4'b1010; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    total++; if (res_valid !== 1'b1 || res_data !== 4'b0000) begin bad++; $display("FAIL equal_res: got v=%b d=%b want 1/0000", res_valid, res_data); end
`ifdef FEEDER_PARITY_EN
    total++; if (res_parity !== 1'b0) begin bad++; $display("FAIL equal_parity: got %b want 0", res_parity); end
`endif
    tick();
    total++; if (res_valid !== 1'b0 || res_data !== 4'b0000) begin bad++; $display("FAIL equal_after: got v=%b d=%b want 0/0000", res_valid, res_data); end
  endtask

  task automatic test_fill();
    logic [3:0] k4;
    out_ready = 1'b0; in_b = 4'h0; in_valid = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      in_a = 4'(k);
      tick();
    end
    in_a = 4'h5;
    total++; if (count !== 3'd4 || in_ready !== 1'b0) begin bad++; $display("FAIL fill_full: got count=%0d in_ready=%b want 4/0", count, in_ready); end
    tick();
    total++; if (count !== 3'd4) begin bad++; $display("FAIL fill_refused: got %0d want 4", count); end
    // full buffer refuses the push even though this edge pops
    out_ready = 1'b1;
    tick();
    total++; if (res_data !== 4'h1 || res_valid !== 1'b1) begin bad++; $display("FAIL fill_res1: got %h v=%b want 1 v=1", res_data, res_valid); end
    total++; if (count !== 3'd3 || in_ready !== 1'b1) begin bad++; $display("FAIL fill_after_pop: got count=%0d in_ready=%b want 3/1", count, in_ready); end
    tick();
    in_valid = 1'b0;
    total++; if (res_data !== 4'h2 || count !== 3'd3) begin bad++; $display("FAIL fill_res2: got %h count=%0d want 2/3", res_data, count); end
    for (int k = 3; k <= 5; k++) begin
      tick();
      k4 = 4'(k);
      total++; if (res_valid !== 1'b1 || res_data !== k4 || count !== 3'(5 - k)) begin bad++; $display("FAIL fill_res%0d: got %h v=%b count=%0d want %h v=1 count=%0d", k, res_data, res_valid, count, k4, 5 - k); end
`ifdef FEEDER_PARITY_EN
      total++; if (res_parity !== ^k4) begin bad++; $display("FAIL fill_parity%0d: got %b want %b", k, res_parity, ^k4); end
`endif
    end
    out_ready = 1'b0;
    tick();
  endtask

  task automatic test_wrap();
    logic [3:0] exp;
    out_ready = 1'b0; in_b = 4'h0; in_valid = 1'b1;
    in_a = 4'h1; tick();
    in_a = 4'h2; tick();
    total++; if (count !== 3'd2) begin bad++; $display("FAIL wrap_prefill: got %0d want 2", count); end
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_a = 4'(3 + i);
      tick();
      exp = 4'(1 + i);
      total++; if (count !== 3'd2 || res_valid !== 1'b1 || res_data !== exp) begin bad++; $display("FAIL wrap_%0d: got count=%0d v=%b d=%h want 2/1/%h", i, count, res_valid, res_data, exp); end
    end
    in_valid = 1'b0;
    tick();
    total++; if (res_data !== 4'd11 || count !== 3'd1) begin bad++; $display("FAIL wrap_drain1: got %h count=%0d want b/1", res_data, count); end
    tick();
    total++; if (res_data !== 4'd12 || count !== 3'd0) begin bad++; $display("FAIL wrap_drain2: got %h count=%0d want c/0", res_data, count); end
    out_ready = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0; in_b = 4'h0; in_valid = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      in_a = 4'(k);
      tick();
    end
    in_a = 4'h4; out_ready = 1'b1;
    tick();
    total++; if (count !== 3'd3 || res_valid !== 1'b1) begin bad++; $display("FAIL mid_setup: got count=%0d v=%b want 3/1", count, res_valid); end
    #2 rst = 1'b1;
    #1;
    total++; if (count !== 3'd0 || out_valid !== 1'b0 || res_valid !== 1'b0) begin bad++; $display("FAIL mid_async: got count=%0d ov=%b rv=%b want 0/0/0", count, out_valid, res_valid); end
    total++; if (in_ready !== 1'b1 || res_data !== 4'h0) begin bad++; $display("FAIL mid_async2: got in_ready=%b d=%h want 1/0", in_ready, res_data); end
    // handshake inputs stay high across an edge while held in reset
    tick();
    total++; if (count !== 3'd0 || res_valid !== 1'b0 || out_valid !== 1'b0) begin bad++; $display("FAIL mid_held: got count=%0d rv=%b ov=%b want 0/0/0", count, res_valid, out_valid); end
    #2 rst = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0;
    tick();
    in_a = 4'b0110; in_b = 4'b0011; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; out_ready = 1'b1;
    total++; if (a !== 4'b0110 || b !== 4'b0011) begin bad++; $display("FAIL mid_fresh_ab: got %b/%b want 0110/0011", a, b); end
    tick();
    out_ready = 1'b0;
    total++; if (res_valid !== 1'b1 || res_data !== 4'b0101) begin bad++; $display("FAIL mid_fresh_res: got v=%b d=%b want 1/0101", res_valid, res_data); end
`ifdef FEEDER_PARITY_EN
    total++; if (res_parity !== 1'b0) begin bad++; $display("FAIL mid_fresh_parity: got %b want 0", res_parity); end
`endif
  endtask

  initial begin
    test_reset();
    test_single();
    test_equal();
    test_fill();
    test_wrap();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/operand_feeder.md
OPERAND_FEEDER -- requirements
Module: operand_feeder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the operand and result width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 4, giving the number of operand-pair entries; DEPTH SHALL be a power of two and at least 2.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset, with ports as follows.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-high reset.
- in_valid  input  1  upstream offers an operand pair.
- in_ready  output  1  the block accepts a pair this cycle.
- in_a  input  WIDTH  first operand.
- in_b  input  WIDTH  second operand.
- a  output  WIDTH  head operand a, to the downstream logic unit.
- b  output  WIDTH  head operand b, to the downstream logic unit.
- out_valid  output  1  a and b hold a valid pair.
- out_ready  input  1  downstream consumes the head pair this cycle.
- result  input  WIDTH  combinational result of the logic unit for the current a and b.
- res_valid  output  1  res_data was updated on the previous clock edge.
- res_data  output  WIDTH  captured result.
- count  output  $clog2(DEPTH)+1  current occupancy.

Function
REQ-004 The block SHALL store operand pairs in a circular buffer with write pointer wp, read pointer rp and occupancy count.
REQ-005 A push SHALL occur on a clock edge when in_valid and in_ready are both 1; the pair is written at wp and wp increments.
REQ-006 in_ready SHALL equal (count < DEPTH) and SHALL depend only on registered state; a push is refused when the buffer is full, even if a pop occurs in the same cycle.
REQ-007 out_valid SHALL equal (count != 0).
REQ-008 a and b SHALL equal the entry at rp whenever out_valid is 1, and SHALL be 0 when the buffer is empty.
REQ-009 A pop SHALL occur on a clock edge when out_valid and out_ready are both 1; rp increments.
REQ-010 On each pop, res_data SHALL capture result and res_valid SHALL be 1 for exactly the following cycle.
REQ-011 When no pop occurs, res_data SHALL hold its value and res_valid SHALL be 0.
REQ-012 Latency SHALL be as follows:
- A pair pushed into an empty buffer appears on a, b and out_valid in the cycle after the push.
- The captured result appears one cycle after the pop.
REQ-013 Pointers SHALL wrap from DEPTH-1 to 0 with no loss and no duplication of entries.
REQ-014 On a simultaneous push and pop, count SHALL be unchanged and both pointers SHALL advance.
REQ-015 A push into an empty buffer in the same cycle that out_ready is 1 SHALL NOT pop, because out_valid is 0 in that cycle.
REQ-016 Entries SHALL be issued in strict FIFO order.
REQ-017 Behaviour under out_ready=1 while out_valid=0 SHALL be a no-op.

Reset
REQ-018 Asserting rst SHALL immediately clear:
- wp, rp and count to 0.
- res_valid to 0.
- res_data to 0.
- the optional res_parity to 0.
REQ-019 While rst is 1, in_ready SHALL be 1 and out_valid SHALL be 0.
REQ-020 A reset asserted mid-operation SHALL discard all buffered pairs; no res_valid pulse SHALL result from a handshake in the reset cycle.
REQ-021 The buffer storage array itself need not be cleared by reset.

Configuration
REQ-022 When macro FEEDER_PARITY_EN is defined, the block SHALL add output res_parity (1 bit).
- res_parity is registered together with res_data on each pop.
- res_parity equals the XOR-reduction of result.
REQ-023 Without FEEDER_PARITY_EN, port res_parity and its register SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-024 Single pair, WIDTH=4, downstream is a 4-bit XOR: push (1101, 0111), then out_ready=1 -> a=1101, b=0111 one cycle after the push; res_data=1010 and res_valid=1 for one cycle after the pop; with the macro, res_parity=0.
REQ-025 Equal operands: push (1010, 1010), then pop -> res_data=0000; with the macro, res_parity=0.
REQ-026 Fill, out_ready=0: push 5 pairs back-to-back (0001,0000) through (0101,0000) -> the first 4 are accepted, count=4 and in_ready=0; the fifth is held by upstream and accepted after the first pop; results then read out 0001, 0010, 0011, 0100, 0101.
REQ-027 Wrap and simultaneous events: with count=2, hold in_valid=1 and out_ready=1 for 10 cycles with incrementing a -> count stays 2; results increment by 1 with no gaps across pointer wrap.
REQ-028 Reset mid-operation: with count=3, assert rst asynchronously between edges -> count=0, out_valid=0 and res_valid=0 immediately; after release, a fresh push of (0110, 0011) yields res_data=0101.
